// File: rtl/alu_decode_stage.sv
// Purpose: decode a MIPS instruction into ALU controls behind a 2-entry skid buffer.
// Latency: 1 cycle from acceptance to the outputs when empty, otherwise once the entry reaches the head.
// Backpressure: in_ready comes from a register and drops only when both entries are occupied.
module alu_decode_stage #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  instr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   af,
  output logic         i,
  output logic         alusrc_imm,
  output logic [n-1:0] imm_ext,
  output logic [4:0]   rs,
  output logic [4:0]   rt,
  output logic [4:0]   rd_dest,
  output logic         reg_write,
  output logic         illegal
);

  typedef struct packed {
    logic [3:0]   af;
    logic         i;
    logic         alusrc_imm;
    logic [n-1:0] imm_ext;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   rd_dest;
    logic         reg_write;
    logic         illegal;
  } entry_t;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0] state_q, state_d;
  entry_t     head_q, head_d;
  entry_t     skid_q, skid_d;
  logic       in_ready_q, in_ready_d;

  entry_t dec;
  logic   is_i, sext, bad;
  logic   push, pop;

  // Combinational decode of the incoming word into one buffer entry.
  always_comb begin
    dec  = '0;
    is_i = 1'b0;
    sext = 1'b0;
    bad  = 1'b0;
    case (instr[31:26])
      6'b000000: begin
        case (instr[5:0])
          6'b100000: dec.af = 4'b0000;
          6'b100001: dec.af = 4'b0001;
          6'b100010: dec.af = 4'b0010;
          6'b100011: dec.af = 4'b0011;
          6'b100100: dec.af = 4'b0100;
          6'b100101: dec.af = 4'b0101;
          6'b100110: dec.af = 4'b0110;
          6'b100111: dec.af = 4'b0111;
          6'b101010: dec.af = 4'b1010;
          6'b101011: dec.af = 4'b1011;
          default:   bad    = 1'b1;
        endcase
      end
      6'b001000: begin dec.af = 4'b0000; is_i = 1'b1; sext = 1'b1; end
      6'b001001: begin dec.af = 4'b0001; is_i = 1'b1; sext = 1'b1; end
      6'b001010: begin dec.af = 4'b1010; is_i = 1'b1; sext = 1'b1; end
      6'b001011: begin dec.af = 4'b1011; is_i = 1'b1; sext = 1'b1; end
      6'b001100: begin dec.af = 4'b0100; is_i = 1'b1; end
      6'b001101: begin dec.af = 4'b0101; is_i = 1'b1; end
      6'b001110: begin dec.af = 4'b0110; is_i = 1'b1; end
      // lui: the ALU does the shift itself from b[15:0], so only i is special here.
      6'b001111: begin dec.af = 4'b0111; is_i = 1'b1; dec.i = 1'b1; end
      default:   bad = 1'b1;
    endcase
    dec.rs        = instr[25:21];
    dec.rt        = instr[20:16];
    dec.reg_write = 1'b1;
    if (is_i) begin
      dec.alusrc_imm = 1'b1;
      dec.rd_dest    = instr[20:16];
      dec.imm_ext    = sext ? {{(n-16){instr[15]}}, instr[15:0]}
                            : {{(n-16){1'b0}}, instr[15:0]};
    end else begin
      dec.rd_dest = instr[15:11];
    end
    // Illegal words still flow through the buffer, with every control field quiet.
    if (bad) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  // Occupancy FSM and entry movement; flush empties the buffer and drops any same-cycle input.
  always_comb begin
    push       = in_valid & in_ready_q;
    pop        = (state_q != S_EMPTY) & out_ready;
    state_d    = state_q;
    head_d     = head_q;
    skid_d     = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (push) begin
            head_d  = dec;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            head_d = dec;
          end else if (push) begin
            skid_d  = dec;
            state_d = S_FULL;
          end else if (pop) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (pop) begin
            head_d  = skid_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
    in_ready_d = (state_d != S_FULL);
  end

  // State registers; reset clears every entry so the outputs read as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != S_EMPTY);
  assign af         = head_q.af;
  assign i          = head_q.i;
  assign alusrc_imm = head_q.alusrc_imm;
  assign imm_ext    = head_q.imm_ext;
  assign rs         = head_q.rs;
  assign rt         = head_q.rt;
  assign rd_dest    = head_q.rd_dest;
  assign reg_write  = head_q.reg_write;
  assign illegal    = head_q.illegal;

endmodule
